// File: rtl/judge_vote_ctrl.sv
// Three-judge vote collector: synchronizes and debounces the judge keys, gathers
// sticky votes over a bounded window, then reports the majority result and keeps tallies.
module judge_vote_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WINDOW_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_a,
  input  logic       key_b,
  input  logic       key_c,
  input  logic       F,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       vote_valid,
  output logic       busy,
  output logic [3:0] pass_cnt,
  output logic [3:0] fail_cnt
);

  localparam logic [7:0]  DebLimit = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] WinInit  = 16'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StLock, StReport} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      lvl_q, lvl_d;
  logic [2:0][7:0] deb_cnt_q, deb_cnt_d;
  logic [15:0]     win_q, win_d;
  logic [2:0]      votes_q, votes_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic [3:0]      pass_q, pass_d;
  logic [3:0]      fail_q, fail_d;
  logic [2:0]      rise;

  always_comb begin
    sync1_d   = {key_c, key_b, key_a};
    sync2_d   = sync1_q;
    lvl_d     = lvl_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (deb_cnt_q[i] + 8'd1 == DebLimit) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
        end
      end
    end
    // Edge taken on the flip itself, so a key held into COLLECT never produces one.
    rise = lvl_d & ~lvl_q;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    votes_d = votes_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCollect;
          votes_d = '0;
          win_d   = WinInit;
          busy_d  = 1'b1;
        end
      end
      StCollect: begin
        // A key edge on the expiry cycle still lands in the vote.
        votes_d = votes_q | rise;
        if (win_q == 16'd0 || &votes_q) begin
          state_d = StLock;
          valid_d = 1'b1;
        end else begin
          win_d = win_q - 16'd1;
        end
      end
      StLock: begin
        state_d = StReport;
        if (F) begin
          if (pass_q != 4'hf) pass_d = pass_q + 4'd1;
        end else begin
          if (fail_q != 4'hf) fail_d = fail_q + 4'd1;
        end
      end
      StReport: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      deb_cnt_q <= '0;
      win_q     <= '0;
      votes_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      deb_cnt_q <= deb_cnt_d;
      win_q     <= win_d;
      votes_q   <= votes_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign A          = votes_q[0];
  assign B          = votes_q[1];
  assign C          = votes_q[2];
  assign vote_valid = valid_q;
  assign busy       = busy_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_judge_vote_ctrl.sv
// Directed bench for judge_vote_ctrl; the downstream stage is modelled as a 2-of-3
// majority with an optional override for the saturation scenario.
module tb_judge_vote_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       key_a = 1'b0, key_b = 1'b0, key_c = 1'b0;
  logic       F;
  logic       A, B, C, vote_valid, busy;
  logic [3:0] pass_cnt, fail_cnt;
  logic       f_ovr_en = 1'b0;
  logic       f_ovr = 1'b0;

  int total = 0;
  int bad = 0;

  assign F = f_ovr_en ? f_ovr : ((A & B) | (A & C) | (B & C));

  judge_vote_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_a     (key_a),
    .key_b     (key_b),
    .key_c     (key_c),
    .F         (F),
    .A         (A),
    .B         (B),
    .C         (C),
    .vote_valid(vote_valid),
    .busy      (busy),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Steps until vote_valid is seen; cycles = -1 when the bound expires.
  task automatic wait_valid(input int max, output int cycles);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (!got && n < max) begin
      step(1);
      n++;
      if (vote_valid) got = 1;
    end
    cycles = got ? n : -1;
  endtask

  task automatic release_keys();
    key_a = 1'b0;
    key_b = 1'b0;
    key_c = 1'b0;
    step(8);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total++;
    if ({A, B, C, vote_valid, busy, pass_cnt, fail_cnt} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {A, B, C, vote_valid, busy, pass_cnt, fail_cnt});
    end
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_window_expiry();
    int cyc;
    do_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL w_busy got=%b exp=1", busy); end
    key_a = 1'b1;
    step(10);
    total++;
    if ({A, C} !== 2'b10) begin bad++; $display("FAIL w_a_mid got=%b exp=10", {A, C}); end
    key_c = 1'b1;
    wait_valid(20, cyc);
    total++;
    if (cyc !== 6) begin bad++; $display("FAIL w_lock_time got=%0d exp=6", cyc); end
    total++;
    if ({A, B, C} !== 3'b101) begin bad++; $display("FAIL w_votes got=%b exp=101", {A, B, C}); end
    step(1);
    total++;
    if (vote_valid !== 1'b0) begin bad++; $display("FAIL w_single_pulse got=%b exp=0", vote_valid); end
    total++;
    if (pass_cnt !== 4'd1 || fail_cnt !== 4'd0) begin
      bad++; $display("FAIL w_tally got=%0d/%0d exp=1/0", pass_cnt, fail_cnt);
    end
    step(1);
    total++;
    if (busy !== 1'b0 || {A, B, C} !== 3'b101) begin
      bad++; $display("FAIL w_idle_hold got=%b%b exp=0101", busy, {A, B, C});
    end
    release_keys();
  endtask

  task automatic test_bounce();
    int cyc;
    do_start();
    key_b = 1'b1; step(1);
    key_b = 1'b0; step(1);
    key_b = 1'b1; step(5);
    total++;
    if (B !== 1'b0) begin bad++; $display("FAIL b_early got=%b exp=0", B); end
    step(1);
    total++;
    if (B !== 1'b1) begin bad++; $display("FAIL b_set got=%b exp=1", B); end
    wait_valid(20, cyc);
    total++;
    if (cyc !== 8) begin bad++; $display("FAIL b_lock_time got=%0d exp=8", cyc); end
    total++;
    if ({A, B, C} !== 3'b010) begin bad++; $display("FAIL b_votes got=%b exp=010", {A, B, C}); end
    step(1);
    total++;
    if (fail_cnt !== 4'd1 || pass_cnt !== 4'd1) begin
      bad++; $display("FAIL b_tally got=%0d/%0d exp=1/1", pass_cnt, fail_cnt);
    end
    step(1);
    release_keys();
  endtask

  task automatic test_early_lock();
    int cyc;
    do_start();
    key_a = 1'b1; step(3);
    key_b = 1'b1; step(4);
    key_c = 1'b1;
    wait_valid(20, cyc);
    total++;
    if (cyc !== 7) begin bad++; $display("FAIL e_lock_time got=%0d exp=7", cyc); end
    total++;
    if ({A, B, C} !== 3'b111) begin bad++; $display("FAIL e_votes got=%b exp=111", {A, B, C}); end
    step(1);
    total++;
    if (busy !== 1'b1 || vote_valid !== 1'b0) begin
      bad++; $display("FAIL e_report got=%b%b exp=10", busy, vote_valid);
    end
    step(1);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL e_busy_fall got=%b exp=0", busy); end
    total++;
    if (pass_cnt !== 4'd2) begin bad++; $display("FAIL e_tally got=%0d exp=2", pass_cnt); end
    release_keys();
  endtask

  task automatic test_held_key();
    int cyc;
    key_a = 1'b1;
    step(8);
    do_start();
    step(2);
    key_a = 1'b0; step(7);
    key_a = 1'b1; step(5);
    total++;
    if (A !== 1'b0) begin bad++; $display("FAIL h_before_repress got=%b exp=0", A); end
    step(1);
    total++;
    if (A !== 1'b1) begin bad++; $display("FAIL h_repress got=%b exp=1", A); end
    wait_valid(20, cyc);
    total++;
    if (cyc !== 1) begin bad++; $display("FAIL h_lock_time got=%0d exp=1", cyc); end
    step(2);
    total++;
    if (fail_cnt !== 4'd2) begin bad++; $display("FAIL h_tally got=%0d exp=2", fail_cnt); end
    // Held through the whole session without a re-press: no vote.
    do_start();
    wait_valid(20, cyc);
    total++;
    if (cyc !== 16 || A !== 1'b0) begin
      bad++; $display("FAIL h_no_repress got=%0d,%b exp=16,0", cyc, A);
    end
    step(2);
    total++;
    if (fail_cnt !== 4'd3) begin bad++; $display("FAIL h_tally2 got=%0d exp=3", fail_cnt); end
    release_keys();
  endtask

  task automatic test_saturation();
    int cyc;
    int exp_pass;
    rst = 1'b1;
    #2;
    total++;
    if (busy !== 1'b0 || pass_cnt !== 4'd0 || fail_cnt !== 4'd0) begin
      bad++; $display("FAIL s_reset got=%b/%0d/%0d exp=0/0/0", busy, pass_cnt, fail_cnt);
    end
    step(1);
    rst = 1'b0;
    step(1);
    f_ovr_en = 1'b1;
    f_ovr = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      do_start();
      step(3);
      do_start();
      wait_valid(20, cyc);
      total++;
      if (cyc !== 12) begin bad++; $display("FAIL s_lock_time[%0d] got=%0d exp=12", k, cyc); end
      start = 1'b1;
      step(1);
      exp_pass = (k > 15) ? 15 : k;
      total++;
      if (pass_cnt !== 4'(exp_pass) || fail_cnt !== 4'd0) begin
        bad++; $display("FAIL s_tally[%0d] got=%0d/%0d exp=%0d/0", k, pass_cnt, fail_cnt, exp_pass);
      end
      step(1);
      start = 1'b0;
      step(1);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL s_no_queue[%0d] got=%b exp=0", k, busy); end
    end
    f_ovr_en = 1'b0;
  endtask

  task automatic test_reset_mid_session();
    int cyc;
    do_start();
    key_a = 1'b1;
    key_b = 1'b1;
    step(8);
    total++;
    if ({A, B, busy} !== 3'b111) begin bad++; $display("FAIL r_pre got=%b exp=111", {A, B, busy}); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({A, B, C, vote_valid, busy, pass_cnt, fail_cnt} !== 13'd0) begin
      bad++;
      $display("FAIL r_async got=%b exp=0", {A, B, C, vote_valid, busy, pass_cnt, fail_cnt});
    end
    key_a = 1'b0;
    key_b = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);
    do_start();
    key_c = 1'b1;
    wait_valid(20, cyc);
    total++;
    if (cyc !== 16 || {A, B, C} !== 3'b001) begin
      bad++; $display("FAIL r_after got=%0d,%b exp=16,001", cyc, {A, B, C});
    end
    step(1);
    total++;
    if (pass_cnt !== 4'd0 || fail_cnt !== 4'd1) begin
      bad++; $display("FAIL r_tally got=%0d/%0d exp=0/1", pass_cnt, fail_cnt);
    end
    step(1);
    release_keys();
  endtask

  initial begin
    test_reset();
    test_window_expiry();
    test_bounce();
    test_early_lock();
    test_held_key();
    test_saturation();
    test_reset_mid_session();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
